// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: core <-> load/store unit bus.
//   memread/memwrite  request strobes (store wins when both are high)
//   funct3            RISC-V load/store width/sign encoding
//   addr              byte address
//   writedata         store data (low byte/half used for SB/SH)
//   readdata          registered, extended load result
//   stall             core must hold while high
//   fault             one-cycle flag for an illegal or misaligned request
interface dmem_lsu_if;
    logic        memread;
    logic        memwrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        stall;
    logic        fault;

    modport master (
        output memread, memwrite, funct3, addr, writedata,
        input  readdata, stall, fault
    );

    modport slave (
        input  memread, memwrite, funct3, addr, writedata,
        output readdata, stall, fault
    );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit with a word-organised data RAM and a fixed
// multi-cycle access latency.
//   clk    clock, rising edge
//   reset  asynchronous, active-high
//   bus    dmem_lsu_if slave: request in, readdata/stall/fault out
// An accepted request spends LATENCY cycles in BUSY; the RAM access happens
// on the last BUSY edge, and the following DONE cycle releases the core.
module dmem_lsu #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic      clk,
    input  logic      reset,
    dmem_lsu_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic          store;
        logic [2:0]    funct3;
        logic [AW-1:0] idx;
        logic [1:0]    lane;
        logic [31:0]   wdata;
    } req_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    req_t          req;
    logic [31:0]   rdata;
    logic [31:0]   mem [DEPTH];

    logic is_req, legal, misaligned;
    logic accept, access, stall, fault;

    // Upper address bits are deliberately dropped so addresses wrap.
    logic unused_addr;
    assign unused_addr = ^bus.addr[31:AW+2];

    // ---------------------------------------------------------------
    // Request decode (only meaningful in IDLE)
    // ---------------------------------------------------------------
    always_comb begin
        is_req     = bus.memread | bus.memwrite;
        legal      = 1'b0;
        misaligned = 1'b0;
        if (bus.memwrite)
            legal = bus.funct3 inside {3'b000, 3'b001, 3'b010};
        else
            legal = bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        // funct3[1:0] gives the access size for every legal encoding
        case (bus.funct3[1:0])
            2'b01:   misaligned = bus.addr[0];
            2'b10:   misaligned = (bus.addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM next state / outputs
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        access     = 1'b0;
        fault      = 1'b0;
        case (state)
            IDLE: begin
                // Nothing is accepted or flagged while reset is held, so
                // stall/fault read 0 even if the core keeps its request up.
                if (is_req && !reset) begin
                    if (legal && !misaligned) begin
                        accept     = 1'b1;
                        state_next = BUSY;
                        cnt_next   = CW'(LATENCY - 1);
                    end else begin
                        fault = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    access     = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            DONE: begin
                // The request still on the bus is the one just completed.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        stall = accept || (state == BUSY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Captured request; the live bus is ignored outside IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req <= '0;
        end else if (accept) begin
            req.store  <= bus.memwrite;
            req.funct3 <= bus.funct3;
            req.idx    <= bus.addr[AW+1:2];
            req.lane   <= bus.addr[1:0];
            req.wdata  <= bus.writedata;
        end
    end

    // ---------------------------------------------------------------
    // Store path: byte enables plus lane-replicated data
    // ---------------------------------------------------------------
    logic [3:0]  be;
    logic [31:0] wlane;

    always_comb begin
        be    = 4'b0000;
        wlane = req.wdata;
        case (req.funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << req.lane;
                wlane = {4{req.wdata[7:0]}};
            end
            2'b01: begin
                be    = req.lane[1] ? 4'b1100 : 4'b0011;
                wlane = {2{req.wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = req.wdata;
            end
        endcase
    end

    // RAM has no reset; access is never high during reset since state is
    // forced to IDLE, so a pending store is simply dropped.
    always_ff @(posedge clk) begin
        if (access && req.store) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[req.idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    // ---------------------------------------------------------------
    // Load path: lane select and extension
    // ---------------------------------------------------------------
    logic [31:0] word, load_val;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        word = mem[req.idx];
        b    = word[{req.lane, 3'b000} +: 8];
        h    = req.lane[1] ? word[31:16] : word[15:0];
        case (req.funct3)
            3'b000:  load_val = {{24{b[7]}}, b};
            3'b001:  load_val = {{16{h[15]}}, h};
            3'b100:  load_val = {24'b0, b};
            3'b101:  load_val = {16'b0, h};
            default: load_val = word;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rdata <= '0;
        else if (access && !req.store)
            rdata <= load_val;
    end

    assign bus.readdata = rdata;
    assign bus.stall    = stall;
    assign bus.fault    = fault;
endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;
    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    dmem_lsu_if bus();

    dmem_lsu #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.memread   = rd;
        bus.memwrite  = wr;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.writedata = wd;
    endtask

    // Present a legal request at a negedge and hold it through DONE; returns
    // #1 after the DONE-cycle negedge so the caller can check readdata.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        drive(rd, wr, f3, a, wd);
        #1;
        check({tag, " stall accept"}, 32'(bus.stall), 32'd1);
        for (int i = 0; i < LATENCY; i++) begin
            @(negedge clk); #1;
            check({tag, " stall busy"}, 32'(bus.stall), 32'd1);
        end
        @(negedge clk); #1;
        check({tag, " stall done"}, 32'(bus.stall), 32'd0);
        check({tag, " fault done"}, 32'(bus.fault), 32'd0);
    endtask

    // Illegal/misaligned request: fault for one cycle, no stall.
    task automatic bad(input string tag, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a);
        @(negedge clk);
        drive(rd, wr, f3, a, 32'hFFFF_FFFF);
        #1;
        check({tag, " fault"}, 32'(bus.fault), 32'd1);
        check({tag, " stall"}, 32'(bus.stall), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        check({tag, " fault clr"}, 32'(bus.fault), 32'd0);
        check({tag, " stall clr"}, 32'(bus.stall), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        check("rst readdata", bus.readdata, 32'h0);
        check("rst stall", 32'(bus.stall), 32'd0);
        check("rst fault", 32'(bus.fault), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Word store/load
        access("sw 10", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        access("lw 10", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        check("lw 10 data", bus.readdata, 32'hDEAD_BEEF);

        // Byte store into an existing word, signed/unsigned byte loads
        access("sw 10b", 1'b0, 1'b1, 3'b010, 32'h10, 32'h1122_3344);
        access("sb 11", 1'b0, 1'b1, 3'b000, 32'h11, 32'h0000_00A5);
        check("sb keeps readdata", bus.readdata, 32'hDEAD_BEEF);
        access("lw 10c", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        check("lw after sb", bus.readdata, 32'h1122_A544);
        access("lb 11", 1'b1, 1'b0, 3'b000, 32'h11, 32'h0);
        check("lb 11 data", bus.readdata, 32'hFFFF_FFA5);
        access("lbu 11", 1'b1, 1'b0, 3'b100, 32'h11, 32'h0);
        check("lbu 11 data", bus.readdata, 32'h0000_00A5);

        // Upper-half store; lower half must stay intact
        access("sw 20", 1'b0, 1'b1, 3'b010, 32'h20, 32'h0);
        access("sh 22", 1'b0, 1'b1, 3'b001, 32'h22, 32'hFFFF_8001);
        access("lh 22", 1'b1, 1'b0, 3'b001, 32'h22, 32'h0);
        check("lh 22 data", bus.readdata, 32'hFFFF_8001);
        access("lhu 22", 1'b1, 1'b0, 3'b101, 32'h22, 32'h0);
        check("lhu 22 data", bus.readdata, 32'h0000_8001);
        access("sw 04", 1'b0, 1'b1, 3'b010, 32'h04, 32'hCAFE_F00D);
        access("lw 20", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        check("lw 20 data", bus.readdata, 32'h8001_0000);

        // Faults: misaligned word, misaligned half store, illegal encodings
        bad("lw 13", 1'b1, 1'b0, 3'b010, 32'h13);
        bad("sh 05", 1'b0, 1'b1, 3'b001, 32'h05);
        bad("ld 011", 1'b1, 1'b0, 3'b011, 32'h10);
        bad("rw 100", 1'b1, 1'b1, 3'b100, 32'h10);
        check("fault keeps readdata", bus.readdata, 32'h8001_0000);
        access("lw 04", 1'b1, 1'b0, 3'b010, 32'h04, 32'h0);
        check("sh 05 no write", bus.readdata, 32'hCAFE_F00D);
        access("lw 10d", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        check("faults no write", bus.readdata, 32'h1122_A544);

        // Address wrap modulo DEPTH*4
        access("sw wrap", 1'b0, 1'b1, 3'b010, 32'(DEPTH * 4 + 8), 32'h5A5A_5A5A);
        access("sw 40", 1'b0, 1'b1, 3'b010, 32'h40, 32'h0);
        access("lw 08", 1'b1, 1'b0, 3'b010, 32'h08, 32'h0);
        check("lw wrap data", bus.readdata, 32'h5A5A_5A5A);

        // Reset during BUSY drops the store
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b010, 32'h40, 32'h1234_5678);
        #1;
        check("sw 40 accept", 32'(bus.stall), 32'd1);
        @(negedge clk);
        #1;
        check("sw 40 busy", 32'(bus.stall), 32'd1);
        reset = 1'b1;
        #1;
        check("mid rst stall", 32'(bus.stall), 32'd0);
        check("mid rst readdata", bus.readdata, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        reset = 1'b0;
        access("lw 08b", 1'b1, 1'b0, 3'b010, 32'h08, 32'h0);
        check("lw 08 again", bus.readdata, 32'h5A5A_5A5A);
        access("lw 40", 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        check("dropped store", bus.readdata, 32'h0);

        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        check("idle stall", 32'(bus.stall), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit and data memory for the rv32 core, sitting directly downstream of the datapath's ALU result and store-data outputs. It holds a word-organised data RAM, performs byte/half/word accesses with RISC-V sign/zero extension, and models a fixed multi-cycle memory latency. While an access is in progress it stalls the core; it also flags misaligned or illegal accesses.

## Interface
- `DEPTH`, 1024: RAM size in 32-bit words; power of two, ≥ 4.
- `LATENCY`, 2: cycles spent in BUSY per access; ≥ 1.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `memread` in 1: load request from the core.
- `memwrite` in 1: store request from the core; wins over `memread` if both are high.
- `funct3` in 3: load encodings 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store encodings 000 SB, 001 SH, 010 SW.
- `addr` in 32: byte address (core `aluout`).
- `writedata` in 32: store data; the low byte or half is used for SB/SH.
- `readdata` out 32: extended load result, registered.
- `stall` out 1: core must hold PC and pipeline state while high.
- `fault` out 1: one-cycle pulse for a misaligned or illegal request.

## Operation
- Word index = `addr[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Byte lane = `addr[1:0]`, little-endian.
- Legal request:
  - loads: funct3 in {000, 001, 010, 100, 101}.
  - stores: funct3 in {000, 001, 010}.
- Misaligned: half access with `addr[0]`=1, or word access with `addr[1:0]`≠0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Request legal and aligned: capture addr, funct3, writedata and op; load counter with LATENCY-1; go to BUSY.
  - Request illegal or misaligned: `fault`=1 this cycle, no access, no state change, `stall`=0, `readdata` unchanged.
  - No request: stay in IDLE.
- BUSY: decrement counter. When the counter is 0, perform the access on that edge and go to DONE.
  - Store: write only the addressed byte lanes.
  - Load: register the extended result into `readdata`.
- DONE: `stall`=0, so the core retires the instruction at this edge. Always go to IDLE next. The request still asserted by the core in DONE is the completed one and is never re-accepted.
- Load extension:
  - LB/LH sign-extend from bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW passes all 32 bits.
- `readdata` holds its value until the next load completes. Stores do not change it.
- RAM contents are not cleared by reset.

## Timing
- Reset values: state IDLE, counter 0, `readdata`=0, `stall`=0, `fault`=0.
- `stall` is combinational: (IDLE and legal aligned request) or BUSY. It is high in the accept cycle, so the core never advances past an accepted access.
- Request accepted in cycle T:
  - `stall` is high in cycles T through T+LATENCY.
  - Cycle T+LATENCY+1 is DONE: `stall`=0 and `readdata` valid.
  - Total stall = LATENCY+1 cycles per access.
- Back-to-back requests: a new request can be accepted in the IDLE cycle immediately following DONE.
- `fault` is combinational. It asserts only in IDLE and never in BUSY or DONE.
- Inputs are ignored in BUSY and DONE; only the captured copies are used.
- Reset asserted mid-access (BUSY): return to IDLE immediately. The pending store is dropped, RAM is unmodified, and `readdata`=0.
- Both `memread` and `memwrite` high: handled as a store. Legality is checked against the store encodings.

## Test plan
- Reset, then SW addr=0x10 data=0xDEADBEEF with LATENCY=2 -> `stall` high 3 cycles then low. LW 0x10 -> `readdata`=0xDEADBEEF in its DONE cycle.
- SB addr=0x11 data=0x000000A5 over word 0x11223344 -> word becomes 0x1122A544. LB 0x11 -> 0xFFFFFFA5. LBU 0x11 -> 0x000000A5.
- SH 0x22 data=0x8001, then LH 0x22 -> 0xFFFF8001 and LHU 0x22 -> 0x00008001.
- LW 0x13, SH 0x05, and load funct3=011 -> `fault` pulses 1 cycle each, `stall`=0, RAM and `readdata` unchanged.
- Wrap-around:
  - SW addr = DEPTH*4 + 8 with data 0x5A5A5A5A -> LW 0x8 returns 0x5A5A5A5A.
  - Two back-to-back LWs -> second accepted in the cycle right after the first's DONE.
- Start SW 0x40 data 0x12345678 (old value 0) and assert `reset` during BUSY -> `stall`=0 immediately. A later LW 0x40 returns 0; `readdata`=0 after reset.
